// File: rtl/wb_sram_responder_pkg.sv
// Shared types and constants for the Wishbone-to-async-SRAM responder.
// Holds the FSM state encoding, the lane-enable encodings, the SRAM address width and wait-state limits.
// Also holds the request record latched at accept time.
package wb_sram_responder_pkg;

    localparam int SRAM_AW = 19;
    localparam int WS_MIN  = 1;
    localparam int WS_MAX  = 15;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH1  = 2'd1,
        ST_PH2  = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    // Active-low lane enables packed as {bhe_n, ble_n}
    typedef enum logic [1:0] {
        LANE_BOTH = 2'b00,
        LANE_HI   = 2'b01,
        LANE_LO   = 2'b10,
        LANE_NONE = 2'b11
    } lane_n_t;

    typedef struct packed {
        logic [19:0] adr;
        logic [15:0] dat;
        logic        we;
        logic        byt;
    } req_t;

    // A word access at an odd byte address needs two SRAM byte cycles
    function automatic logic is_split(input logic adr0, input logic byt);
        return adr0 & ~byt;
    endfunction

endpackage

// File: rtl/wb_sram_lane_steer.sv
// Combinational lane steering: picks lane enables, write-data placement and the read byte lane.
// Zero latency; pure function of the latched request and the current phase.
// No flow control of its own; the parent FSM decides when the outputs matter.
module wb_sram_lane_steer
    import wb_sram_responder_pkg::*;
(
    input  logic        active,
    input  logic        adr0,
    input  logic        byt,
    input  logic        ph2,
    input  logic [15:0] wdat,
    input  logic [15:0] rdat,
    output lane_n_t     lane_n,
    output logic [15:0] sram_wdat,
    output logic [7:0]  rd_byte
);

    logic split;
    logic use_hi;

    assign split = is_split(adr0, byt);

    // High lane is used by odd bytes and by the first half of an odd word
    assign use_hi = (byt & adr0) | (split & ~ph2);

    // Lane enables, write placement and read lane selection
    always_comb begin
        lane_n    = LANE_NONE;
        sram_wdat = wdat;
        if (active) begin
            if (!byt && !adr0) begin
                lane_n = LANE_BOTH;
            end else begin
                lane_n = use_hi ? LANE_HI : LANE_LO;
            end
        end
        // Byte data is replicated on both lanes so the enabled lane always carries it
        if (byt) begin
            sram_wdat = {wdat[7:0], wdat[7:0]};
        end else if (split) begin
            sram_wdat = ph2 ? {wdat[15:8], wdat[15:8]} : {wdat[7:0], wdat[7:0]};
        end
        rd_byte = use_hi ? rdat[15:8] : rdat[7:0];
    end

endmodule

// File: rtl/wb_sram_responder.sv
// Wishbone memory-space responder driving a 512K x 16 async SRAM with WAIT_STATES+1 cycles per phase.
// Ack in cycle W+2 after accept (2W+3 for odd-address words, split into two byte phases).
// No backpressure beyond stb/ack; I/O-space requests are ignored and never acked.
module wb_sram_responder
    import wb_sram_responder_pkg::*;
#(
    parameter int WAIT_STATES = 1
)
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [19:0]         wb_adr_i,
    input  logic [15:0]         wb_dat_i,
    output logic [15:0]         wb_dat_o,
    input  logic                wb_we_i,
    input  logic                wb_mio_i,
    input  logic                wb_byte_i,
    input  logic                wb_stb_i,
    output logic                wb_ack_o,
    output logic [SRAM_AW-1:0]  sram_addr_o,
    input  logic [15:0]         sram_dat_i,
    output logic [15:0]         sram_dat_o,
    output logic                sram_dat_oe_o,
    output logic                sram_ce_n_o,
    output logic                sram_oe_n_o,
    output logic                sram_we_n_o,
    output logic                sram_ble_n_o,
    output logic                sram_bhe_n_o
);

    if (WAIT_STATES < WS_MIN || WAIT_STATES > WS_MAX) begin : g_bad_ws
        $error("wb_sram_responder: WAIT_STATES out of range");
    end

    localparam logic [CNT_W-1:0] WS_L = CNT_W'(WAIT_STATES);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    req_t               req;
    logic [7:0]         rd_lo;

    logic               in_phase;
    logic               ph2;
    logic               split;
    logic               last_cyc;
    logic [SRAM_AW-1:0] word_adr;
    lane_n_t            lane_n;
    logic [15:0]        steer_wdat;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_final;

    assign in_phase = (state == ST_PH1) || (state == ST_PH2);
    assign ph2      = (state == ST_PH2);
    assign split    = is_split(req.adr[0], req.byt);
    assign last_cyc = (cnt == WS_L);
    assign word_adr = req.adr[19:1];

    wb_sram_lane_steer u_steer (
        .active    (in_phase),
        .adr0      (req.adr[0]),
        .byt       (req.byt),
        .ph2       (ph2),
        .wdat      (req.dat),
        .rdat      (sram_dat_i),
        .lane_n    (lane_n),
        .sram_wdat (steer_wdat),
        .rd_byte   (rd_byte)
    );

    // SRAM pin decode from registered state; everything idles outside PH1/PH2
    always_comb begin
        sram_ce_n_o   = ~in_phase;
        sram_oe_n_o   = ~(in_phase & ~req.we);
        // we_n releases on the final cycle of each phase to give data hold time
        sram_we_n_o   = ~(in_phase & req.we & ~last_cyc);
        sram_dat_oe_o = in_phase & req.we;
        sram_addr_o   = '0;
        if (in_phase) begin
            sram_addr_o = ph2 ? (word_adr + SRAM_AW'(1)) : word_adr;
        end
        sram_dat_o    = sram_dat_oe_o ? steer_wdat : 16'h0000;
        {sram_bhe_n_o, sram_ble_n_o} = lane_n;
    end

    // Final read word as it will be presented at ack time
    always_comb begin
        rd_final = sram_dat_i;
        if (split) begin
            rd_final = {rd_byte, rd_lo};
        end else if (req.byt) begin
            rd_final = {8'h00, rd_byte};
        end
    end

    // Request FSM, wait counter and read assembly; ACK behaves like IDLE on its exit edge
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            req      <= '0;
            rd_lo    <= 8'h00;
            wb_ack_o <= 1'b0;
            wb_dat_o <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE, ST_ACK: begin
                    wb_ack_o <= 1'b0;
                    if (wb_stb_i && wb_mio_i) begin
                        req.adr <= wb_adr_i;
                        req.dat <= wb_dat_i;
                        req.we  <= wb_we_i;
                        req.byt <= wb_byte_i;
                        cnt     <= '0;
                        state   <= ST_PH1;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                ST_PH1: begin
                    if (last_cyc) begin
                        cnt <= '0;
                        if (split) begin
                            if (!req.we) begin
                                rd_lo <= rd_byte;
                            end
                            state <= ST_PH2;
                        end else begin
                            if (!req.we) begin
                                wb_dat_o <= rd_final;
                            end
                            wb_ack_o <= 1'b1;
                            state    <= ST_ACK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_PH2: begin
                    if (last_cyc) begin
                        cnt <= '0;
                        if (!req.we) begin
                            wb_dat_o <= rd_final;
                        end
                        wb_ack_o <= 1'b1;
                        state    <= ST_ACK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wb_ack_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_responder.sv
// Self-checking bench: byte-addressed reference memory plus a word SRAM model.
// Directed scenarios and randomized transactions check data, lanes, timing and reset.
module tb_wb_sram_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] adr;
    logic [15:0] wdat;
    logic        we, mio, byt, stb;
    logic        ack;
    logic [15:0] rdat;
    logic [18:0] saddr;
    logic [15:0] srd, swd;
    logic        soe, ce_n, oe_n, we_n, ble_n, bhe_n;

    int total = 0;
    int bad   = 0;

    bit [15:0] sram [0:524287];
    bit [7:0]  ref_b [bit [19:0]];

    typedef struct {
        logic [18:0] addr;
        logic        bhe_n, ble_n, we_n, oe_n, oe;
        logic [15:0] dat;
    } tr_t;
    tr_t tr_q[$];

    always #5 clk = ~clk;

    assign srd = (!ce_n && !oe_n) ? sram[saddr] : 16'h0000;

    wb_sram_responder #(.WAIT_STATES(W)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat),
        .wb_we_i(we), .wb_mio_i(mio), .wb_byte_i(byt),
        .wb_stb_i(stb), .wb_ack_o(ack),
        .sram_addr_o(saddr), .sram_dat_i(srd), .sram_dat_o(swd),
        .sram_dat_oe_o(soe), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n),
        .sram_we_n_o(we_n), .sram_ble_n_o(ble_n), .sram_bhe_n_o(bhe_n)
    );

    // ---------------- reference model (byte-addressed, little-endian) ----------------
    function automatic logic [7:0] rb(input logic [19:0] a);
        return ref_b.exists(a) ? ref_b[a] : 8'h00;
    endfunction

    function automatic logic [15:0] ref_read(input logic [19:0] a, input logic b);
        logic [19:0] a1;
        a1 = a + 20'd1;
        return b ? {8'h00, rb(a)} : {rb(a1), rb(a)};
    endfunction

    task automatic ref_write(input logic [19:0] a, input logic [15:0] d, input logic b);
        logic [19:0] a1;
        a1 = a + 20'd1;
        ref_b[a] = d[7:0];
        if (!b) ref_b[a1] = d[15:8];
    endtask

    function automatic logic [15:0] ref_word(input logic [18:0] wa);
        return {rb({wa, 1'b1}), rb({wa, 1'b0})};
    endfunction

    function automatic int exp_lat(input logic [19:0] a, input logic b);
        return (a[0] && !b) ? 2 * W + 2 : W + 1;
    endfunction

    task automatic poke(input logic [18:0] wa, input logic [15:0] v);
        sram[wa] = v;
        ref_b[{wa, 1'b0}] = v[7:0];
        ref_b[{wa, 1'b1}] = v[15:8];
    endtask

    // One Wishbone transaction; records SRAM pin activity and applies SRAM writes
    task automatic do_txn(input logic [19:0] a, input logic [15:0] d, input logic w, input logic b,
                          output logic [15:0] r, output int lat, output bit to);
        int n;
        tr_t e;
        n = 0; to = 0;
        tr_q.delete();
        @(negedge clk);
        adr = a; wdat = d; we = w; byt = b; mio = 1'b1; stb = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ack) break;
            if (!ce_n) begin
                e.addr = saddr; e.bhe_n = bhe_n; e.ble_n = ble_n; e.we_n = we_n;
                e.oe_n = oe_n; e.oe = soe; e.dat = swd;
                tr_q.push_back(e);
                if (!we_n) begin
                    if (!ble_n) sram[saddr][7:0]  = swd[7:0];
                    if (!bhe_n) sram[saddr][15:8] = swd[15:8];
                end
            end
            n++;
            if (n > 100) begin to = 1; break; end
        end
        r = rdat; lat = n;
        @(negedge clk);
        stb = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0; stb = 1'b0; mio = 1'b1; we = 1'b0; byt = 1'b0; adr = '0; wdat = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (ack !== 1'b0 || rdat !== 16'h0000)
            begin bad++; $display("FAIL rst_wb ack=%b dat=%h want ack=0 dat=0000", ack, rdat); end
        total++;
        if ({ce_n, oe_n, we_n, ble_n, bhe_n, soe} !== 6'b111110)
            begin bad++; $display("FAIL rst_ctl ce,oe,we,ble,bhe,doe=%b want 111110", {ce_n, oe_n, we_n, ble_n, bhe_n, soe}); end
        total++;
        if (saddr !== 19'h0 || swd !== 16'h0)
            begin bad++; $display("FAIL rst_bus addr=%h dat=%h want 0", saddr, swd); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_aligned_write;
        logic [15:0] r; int lat; bit to; int err; int wl;
        ref_write(20'h00010, 16'hBEEF, 1'b0);
        do_txn(20'h00010, 16'hBEEF, 1'b1, 1'b0, r, lat, to);
        total++;
        if (to || lat !== W + 1)
            begin bad++; $display("FAIL aw_latency got=%0d want=%0d", lat, W + 1); end
        err = 0; wl = 0;
        foreach (tr_q[i]) begin
            if (tr_q[i].addr !== 19'h8 || tr_q[i].bhe_n !== 1'b0 || tr_q[i].ble_n !== 1'b0 ||
                tr_q[i].dat !== 16'hBEEF || tr_q[i].oe !== 1'b1 || tr_q[i].oe_n !== 1'b1) err++;
            if (tr_q[i].we_n === 1'b0) wl++;
        end
        total++;
        if (tr_q.size() != W + 1 || err != 0 || wl != W || tr_q[tr_q.size()-1].we_n !== 1'b1)
            begin bad++; $display("FAIL aw_pins cycles=%0d errs=%0d we_low=%0d want cycles=%0d errs=0 we_low=%0d", tr_q.size(), err, wl, W + 1, W); end
        total++;
        if (sram[19'h8] !== ref_word(19'h8))
            begin bad++; $display("FAIL aw_mem got=%h want=%h", sram[19'h8], ref_word(19'h8)); end
    endtask

    task automatic test_odd_read;
        logic [15:0] r; int lat; bit to; int err;
        poke(19'h10, 16'h12AB);
        poke(19'h11, 16'h34CD);
        do_txn(20'h00021, 16'h0, 1'b0, 1'b0, r, lat, to);
        total++;
        if (to || lat !== 2 * W + 2)
            begin bad++; $display("FAIL or_latency got=%0d want=%0d", lat, 2 * W + 2); end
        err = 0;
        foreach (tr_q[i]) begin
            if (i <= W) begin
                if (tr_q[i].addr !== 19'h10 || tr_q[i].bhe_n !== 1'b0 || tr_q[i].ble_n !== 1'b1) err++;
            end else begin
                if (tr_q[i].addr !== 19'h11 || tr_q[i].bhe_n !== 1'b1 || tr_q[i].ble_n !== 1'b0) err++;
            end
            if (tr_q[i].oe_n !== 1'b0 || tr_q[i].we_n !== 1'b1 || tr_q[i].oe !== 1'b0) err++;
        end
        total++;
        if (tr_q.size() != 2 * (W + 1) || err != 0)
            begin bad++; $display("FAIL or_pins cycles=%0d errs=%0d want cycles=%0d errs=0", tr_q.size(), err, 2 * (W + 1)); end
        total++;
        if (r !== ref_read(20'h00021, 1'b0))
            begin bad++; $display("FAIL or_data got=%h want=%h", r, ref_read(20'h00021, 1'b0)); end
    endtask

    task automatic test_byte_write;
        logic [15:0] r; int lat; bit to; int err; int wl;
        poke(19'h1, 16'h7788);
        ref_write(20'h00003, 16'h0055, 1'b1);
        do_txn(20'h00003, 16'h0055, 1'b1, 1'b1, r, lat, to);
        total++;
        if (to || lat !== W + 1)
            begin bad++; $display("FAIL bw_latency got=%0d want=%0d", lat, W + 1); end
        err = 0; wl = 0;
        foreach (tr_q[i]) begin
            if (tr_q[i].addr !== 19'h1 || tr_q[i].bhe_n !== 1'b0 || tr_q[i].ble_n !== 1'b1 ||
                tr_q[i].dat[15:8] !== 8'h55) err++;
            if (tr_q[i].we_n === 1'b0) wl++;
        end
        total++;
        if (tr_q.size() != W + 1 || err != 0 || wl != W)
            begin bad++; $display("FAIL bw_pins cycles=%0d errs=%0d we_low=%0d want %0d/0/%0d", tr_q.size(), err, wl, W + 1, W); end
        total++;
        if (sram[19'h1] !== ref_word(19'h1))
            begin bad++; $display("FAIL bw_mem got=%h want=%h", sram[19'h1], ref_word(19'h1)); end
    endtask

    task automatic test_wrap_write;
        logic [15:0] r; int lat; bit to; int err;
        ref_write(20'hFFFFF, 16'hA1B2, 1'b0);
        do_txn(20'hFFFFF, 16'hA1B2, 1'b1, 1'b0, r, lat, to);
        err = 0;
        foreach (tr_q[i]) begin
            if (i <= W) begin
                if (tr_q[i].addr !== 19'h7FFFF || tr_q[i].bhe_n !== 1'b0 || tr_q[i].ble_n !== 1'b1 ||
                    tr_q[i].dat[15:8] !== 8'hB2) err++;
            end else begin
                if (tr_q[i].addr !== 19'h00000 || tr_q[i].bhe_n !== 1'b1 || tr_q[i].ble_n !== 1'b0 ||
                    tr_q[i].dat[7:0] !== 8'hA1) err++;
            end
            if (tr_q[i].we_n !== (i == W || i == 2 * W + 1)) err++;
        end
        total++;
        if (to || tr_q.size() != 2 * (W + 1) || err != 0)
            begin bad++; $display("FAIL wrap_pins cycles=%0d errs=%0d want cycles=%0d errs=0", tr_q.size(), err, 2 * (W + 1)); end
        total++;
        if (sram[19'h7FFFF] !== ref_word(19'h7FFFF) || sram[19'h0] !== ref_word(19'h0))
            begin bad++; $display("FAIL wrap_mem got=%h,%h want=%h,%h", sram[19'h7FFFF], sram[19'h0], ref_word(19'h7FFFF), ref_word(19'h0)); end
    endtask

    task automatic test_io;
        int err;
        err = 0;
        @(negedge clk);
        adr = 20'h00040; wdat = 16'h1234; we = 1'b1; byt = 1'b0; mio = 1'b0; stb = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (ack !== 1'b0 || {ce_n, oe_n, we_n, ble_n, bhe_n} !== 5'b11111 || soe !== 1'b0) err++;
        end
        total++;
        if (err != 0)
            begin bad++; $display("FAIL io_ignored bad_cycles=%0d want 0", err); end
        @(negedge clk);
        stb = 1'b0; mio = 1'b1;
    endtask

    task automatic test_random;
        logic [15:0] r, last_rd, d; logic [19:0] a; logic w, b;
        int lat; bit to; int n_err;
        do_txn(20'h00020, 16'h0, 1'b0, 1'b0, r, lat, to);
        last_rd = ref_read(20'h00020, 1'b0);
        n_err = 0;
        for (int k = 0; k < 40; k++) begin
            a = ($urandom_range(0, 3) == 0) ? (20'hFFFC0 + 20'($urandom_range(0, 63)))
                                            : 20'($urandom_range(0, 63));
            d = 16'($urandom);
            w = 1'($urandom);
            b = 1'($urandom);
            if (w) ref_write(a, d, b);
            do_txn(a, d, w, b, r, lat, to);
            total++;
            if (to || lat !== exp_lat(a, b))
                begin bad++; $display("FAIL rnd_latency k=%0d adr=%h got=%0d want=%0d", k, a, lat, exp_lat(a, b)); end
            if (!w) begin
                last_rd = ref_read(a, b);
                total++;
                if (r !== last_rd)
                    begin bad++; $display("FAIL rnd_read k=%0d adr=%h byte=%b got=%h want=%h", k, a, b, r, last_rd); end
            end else begin
                total++;
                if (sram[a[19:1]] !== ref_word(a[19:1]) || r !== last_rd)
                    begin bad++; $display("FAIL rnd_write k=%0d adr=%h mem=%h want=%h dat_o=%h want=%h", k, a, sram[a[19:1]], ref_word(a[19:1]), r, last_rd); end
                if (!b && a[0]) begin
                    total++;
                    if (sram[a[19:1] + 19'd1] !== ref_word(a[19:1] + 19'd1))
                        begin bad++; $display("FAIL rnd_split_mem k=%0d adr=%h got=%h want=%h", k, a, sram[a[19:1] + 19'd1], ref_word(a[19:1] + 19'd1)); end
                end
            end
            if (to) n_err++;
            if (n_err > 3) break;
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        adr = 20'h00021; we = 1'b0; byt = 1'b0; mio = 1'b1; stb = 1'b1;
        repeat (W + 2) @(posedge clk);
        #1;
        total++;
        if (saddr !== 19'h11 || ce_n !== 1'b0)
            begin bad++; $display("FAIL rm_in_ph2 addr=%h ce_n=%b want addr=00011 ce_n=0", saddr, ce_n); end
        @(negedge clk);
        rst_n = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ack !== 1'b0 || rdat !== 16'h0 || {ce_n, oe_n, we_n, ble_n, bhe_n, soe} !== 6'b111110 ||
            saddr !== 19'h0 || swd !== 16'h0)
            begin bad++; $display("FAIL rm_reset ack=%b dat=%h ctl=%b addr=%h wd=%h want 0/0000/111110/0/0", ack, rdat, {ce_n, oe_n, we_n, ble_n, bhe_n, soe}, saddr, swd); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ack !== 1'b0 || ce_n !== 1'b1)
            begin bad++; $display("FAIL rm_after ack=%b ce_n=%b want 0 1", ack, ce_n); end
    endtask

    task automatic test_back_to_back;
        int n1, n2;
        poke(19'h40, 16'h1111);
        poke(19'h41, 16'h2222);
        @(negedge clk);
        adr = 20'h00080; we = 1'b0; byt = 1'b0; mio = 1'b1; stb = 1'b1;
        n1 = 0;
        do begin @(posedge clk); #1; n1++; end while (!ack && n1 < 100);
        total++;
        if (!ack || rdat !== ref_read(20'h00080, 1'b0))
            begin bad++; $display("FAIL b2b_first ack=%b dat=%h want 1 %h", ack, rdat, ref_read(20'h00080, 1'b0)); end
        adr = 20'h00082;
        n2 = 0;
        do begin @(posedge clk); #1; n2++; end while (!ack && n2 < 100);
        total++;
        if (n2 != W + 2)
            begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", n2, W + 2); end
        total++;
        if (rdat !== ref_read(20'h00082, 1'b0))
            begin bad++; $display("FAIL b2b_second dat=%h want=%h", rdat, ref_read(20'h00082, 1'b0)); end
        @(negedge clk);
        stb = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ack !== 1'b0)
            begin bad++; $display("FAIL b2b_single_ack ack=%b want 0", ack); end
    endtask

    initial begin
        test_reset();
        test_aligned_write();
        test_odd_read();
        test_byte_write();
        test_wrap_write();
        test_io();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
